hilo_mul_ctrl: RTL and testbench

- Multiply-unit controller in the EX stage. Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU requests from the pipeline.
- Drives registered operands and the sign select into the pipelined Booth/Wallace multiplier core, then waits out the core's register latency.
- Consumes the core's 64-bit product, accumulates or subtracts it against HI/LO where required, and writes the HI/LO architectural register pair.
- Also services MTHI/MTLO writes and pipeline flush.

---
 rtl/hilo_mul_ctrl_if.sv | 67 ++++++
 rtl/hilo_mul_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_hilo_mul_ctrl.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_mul_ctrl_if.sv
// -----------------------------------------------------------------------------
// hilo_mul_ctrl_if
//
// Purpose:
//    Bundles every non-clock, non-reset signal of the HI/LO multiply
//    controller. This covers the EX-stage request handshake, the MTHI/MTLO
//    moves, the flush, the multiplier-core operand/product path and the
//    HI/LO result outputs.
//
// Modports:
//    master : the pipeline / multiplier-core side. It drives requests, moves,
//             flush and the core product. It observes the status, the core
//             operands and HI/LO.
//    slave  : the controller side (hilo_mul_ctrl).
//
// Signal summary (direction as seen by the controller):
//    req_valid  in   EX presents a multiply request
//    req_ready  out  controller idle, request can be accepted
//    req_op     in   3-bit op: MULT/MULTU/MADD/MADDU/MSUB/MSUBU, 11x reserved
//    req_a      in   rs operand
//    req_b      in   rt operand
//    flush      in   kill the in-flight operation / block an accept
//    mthi_we    in   write HI from mt_data
//    mtlo_we    in   write LO from mt_data
//    mt_data    in   MTHI/MTLO data
//    mc_op1     out  core operand 1 (registered)
//    mc_op2     out  core operand 2 (registered)
//    mc_sign_en out  core signed-mode select (registered)
//    mc_out     in   core 64-bit product
//    busy       out  operation in flight
//    done       out  one-cycle pulse, HI/LO hold the result
//    hi_o       out  HI register
//    lo_o       out  LO register
// -----------------------------------------------------------------------------
interface hilo_mul_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        flush;
   logic        mthi_we;
   logic        mtlo_we;
   logic [31:0] mt_data;
   logic [31:0] mc_op1;
   logic [31:0] mc_op2;
   logic        mc_sign_en;
   logic [63:0] mc_out;
   logic        busy;
   logic        done;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   modport master (
      output req_valid, req_op, req_a, req_b, flush,
             mthi_we, mtlo_we, mt_data, mc_out,
      input  req_ready, mc_op1, mc_op2, mc_sign_en,
             busy, done, hi_o, lo_o
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, flush,
             mthi_we, mtlo_we, mt_data, mc_out,
      output req_ready, mc_op1, mc_op2, mc_sign_en,
             busy, done, hi_o, lo_o
   );
endinterface

// File: rtl/hilo_mul_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_mul_ctrl
//
// Purpose:
//    EX-stage multiply-unit controller. It accepts MULT/MULTU/MADD/MADDU/
//    MSUB/MSUBU requests and presents registered operands plus the sign select
//    to an external pipelined multiplier core. It waits MC_LAT clock edges for
//    the product, then writes HI/LO. The write is the plain product, or
//    {HI,LO} plus or minus the product for the accumulate forms. The module
//    also services MTHI/MTLO moves and pipeline flush.
//
// Parameters:
//    MC_LAT   : register stages inside the multiplier core, legal 1..4
//    HILO_RST : reset value of {HI,LO}
//
// Ports:
//    clk  : system clock, rising edge
//    rstn : asynchronous active-low reset
//    bus  : hilo_mul_ctrl_if.slave (handshake, moves, core path, HI/LO)
//
// Build option:
//    HILO_FWD_EN : when defined, hi_o/lo_o combinationally show the value
//                  being written during WB. done then pulses in the WB cycle
//                  instead of the cycle after it.
//
// Timing (default build): accept at edge E0, HI/LO written at E0+MC_LAT+1,
// done high during the following cycle, which is already IDLE.
// -----------------------------------------------------------------------------
module hilo_mul_ctrl #(
   parameter int          MC_LAT   = 1,
   parameter logic [63:0] HILO_RST = 64'h0
) (
   input  logic              clk,
   input  logic              rstn,
   hilo_mul_ctrl_if.slave    bus
);

   // FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_WB   = 2'd2;

   // Op encodings
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_MADD  = 3'b010;
   localparam logic [2:0] OP_MADDU = 3'b011;
   localparam logic [2:0] OP_MSUB  = 3'b100;
   localparam logic [2:0] OP_MSUBU = 3'b101;

   // WAIT exits when the counter reaches MC_LAT-1. MC_LAT is at most 4, so
   // 2 bits are enough.
   localparam logic [1:0] CNT_LAST = 2'(MC_LAT - 1);

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [1:0]  r_state;
   logic [1:0]  r_cnt;
   logic [2:0]  r_op;
   logic [31:0] r_op1;
   logic [31:0] r_op2;
   logic        r_sign_en;
   logic [63:0] r_hilo;
`ifndef HILO_FWD_EN
   logic        r_done;
`endif

   // --------------------------------------------------------------------------
   // Combinational helpers
   // --------------------------------------------------------------------------
   logic        w_idle;
   logic        w_accept;
   logic        w_wb_we;
   logic [63:0] w_wb_val;

   assign w_idle   = (r_state == ST_IDLE);
   // A flush in IDLE vetoes an accept in the same cycle.
   assign w_accept = w_idle & bus.req_valid & ~bus.flush;

   // Reserved ops (11x) still run through WAIT/WB and pulse done, but write
   // nothing.
   assign w_wb_we  = (r_op[2:1] != 2'b11);

   // WB result, always computed against the current architectural {HI,LO}.
   // This includes a value moved in at the accept edge. Arithmetic wraps
   // modulo 2^64.
   always_comb begin
      w_wb_val = r_hilo;
      case (r_op)
         OP_MULT, OP_MULTU: w_wb_val = bus.mc_out;
         OP_MADD, OP_MADDU: w_wb_val = r_hilo + bus.mc_out;
         OP_MSUB, OP_MSUBU: w_wb_val = r_hilo - bus.mc_out;
         default:           w_wb_val = r_hilo;
      endcase
   end

   // --------------------------------------------------------------------------
   // Sequential control
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 2'd0;
         r_op      <= 3'd0;
         r_op1     <= 32'd0;
         r_op2     <= 32'd0;
         r_sign_en <= 1'b0;
         r_hilo    <= HILO_RST;
`ifndef HILO_FWD_EN
         r_done    <= 1'b0;
`endif
      end else begin
`ifndef HILO_FWD_EN
         r_done <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               // Moves are honoured only here. While busy the pipeline is
               // stalled, so a move then is an illegal sequence and is dropped.
               if (bus.mthi_we) begin
                  r_hilo[63:32] <= bus.mt_data;
               end
               if (bus.mtlo_we) begin
                  r_hilo[31:0] <= bus.mt_data;
               end
               if (w_accept) begin
                  r_op1     <= bus.req_a;
                  r_op2     <= bus.req_b;
                  // Even ops (MULT/MADD/MSUB) are the signed forms.
                  r_sign_en <= ~bus.req_op[0];
                  r_op      <= bus.req_op;
                  r_cnt     <= 2'd0;
                  r_state   <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               // Operands stay frozen so the core sees stable inputs for
               // MC_LAT edges.
               if (bus.flush) begin
                  r_cnt   <= 2'd0;
                  r_state <= ST_IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  r_cnt   <= 2'd0;
                  r_state <= ST_WB;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end

            ST_WB: begin
               r_state <= ST_IDLE;
               if (!bus.flush) begin
                  if (w_wb_we) begin
                     r_hilo <= w_wb_val;
                  end
`ifndef HILO_FWD_EN
                  r_done <= 1'b1;
`endif
               end
            end

            default: begin
               r_cnt   <= 2'd0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign bus.req_ready  = w_idle;
   assign bus.busy       = ~w_idle;
   assign bus.mc_op1     = r_op1;
   assign bus.mc_op2     = r_op2;
   assign bus.mc_sign_en = r_sign_en;

`ifdef HILO_FWD_EN
   // Forward the WB value so consumers see it one cycle early. On a flush in
   // WB the forwarded value is meaningless, and done stays low to mark that.
   logic w_in_wb;
   assign w_in_wb  = (r_state == ST_WB);
   assign bus.hi_o = w_in_wb ? w_wb_val[63:32] : r_hilo[63:32];
   assign bus.lo_o = w_in_wb ? w_wb_val[31:0]  : r_hilo[31:0];
   assign bus.done = w_in_wb & ~bus.flush;
`else
   assign bus.hi_o = r_hilo[63:32];
   assign bus.lo_o = r_hilo[31:0];
   assign bus.done = r_done;
`endif

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_mul_ctrl
//
// Directed bench for hilo_mul_ctrl. Two instances are used:
//    dut1 : MC_LAT=1, HILO_RST=0
//    dut3 : MC_LAT=3, HILO_RST=64'h12345678_9ABCDEF0
// Each instance has a behavioural multiplier core with the matching number of
// register stages. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_hilo_mul_ctrl;

   localparam logic [63:0] RST3 = 64'h12345678_9ABCDEF0;

   logic clk;
   logic rstn1;
   logic rstn3;

   int n_checks;
   int n_fail;

   hilo_mul_ctrl_if bus1();
   hilo_mul_ctrl_if bus3();

   hilo_mul_ctrl #(.MC_LAT(1), .HILO_RST(64'h0)) dut1 (
      .clk  (clk),
      .rstn (rstn1),
      .bus  (bus1)
   );

   hilo_mul_ctrl #(.MC_LAT(3), .HILO_RST(RST3)) dut3 (
      .clk  (clk),
      .rstn (rstn3),
      .bus  (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural multiplier core: signed or unsigned 32x32 product
   function automatic logic [63:0] core_mul(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic s);
      logic [63:0] ea;
      logic [63:0] eb;
      if (s) begin
         ea = {{32{a[31]}}, a};
         eb = {{32{b[31]}}, b};
      end else begin
         ea = {32'd0, a};
         eb = {32'd0, b};
      end
      return ea * eb;
   endfunction

   // One register stage for dut1
   always @(posedge clk) begin
      bus1.mc_out <= core_mul(bus1.mc_op1, bus1.mc_op2, bus1.mc_sign_en);
   end

   // Three register stages for dut3
   logic [63:0] c3_s1;
   logic [63:0] c3_s2;
   always @(posedge clk) begin
      c3_s1       <= core_mul(bus3.mc_op1, bus3.mc_op2, bus3.mc_sign_en);
      c3_s2       <= c3_s1;
      bus3.mc_out <= c3_s2;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus1.req_valid = 1'b0; bus1.req_op = 3'd0; bus1.req_a = 32'd0; bus1.req_b = 32'd0;
      bus1.flush = 1'b0; bus1.mthi_we = 1'b0; bus1.mtlo_we = 1'b0; bus1.mt_data = 32'd0;
      bus3.req_valid = 1'b0; bus3.req_op = 3'd0; bus3.req_a = 32'd0; bus3.req_b = 32'd0;
      bus3.flush = 1'b0; bus3.mthi_we = 1'b0; bus3.mtlo_we = 1'b0; bus3.mt_data = 32'd0;
   endtask

   task automatic req1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus1.req_valid = 1'b1;
      bus1.req_op    = op;
      bus1.req_a     = a;
      bus1.req_b     = b;
   endtask

   // --------------------------------------------------------------------------
   task automatic test_reset();
      n_checks++;
      if ({bus1.hi_o, bus1.lo_o} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_hilo1: got %h_%h expected 0", bus1.hi_o, bus1.lo_o);
      end
      n_checks++;
      if ({bus1.busy, bus1.req_ready, bus1.done, bus1.mc_sign_en} !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_status1: busy/ready/done/sign got %b expected 0100",
                  {bus1.busy, bus1.req_ready, bus1.done, bus1.mc_sign_en});
      end
      n_checks++;
      if ({bus1.mc_op1, bus1.mc_op2} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_ops1: got %h %h expected 0 0", bus1.mc_op1, bus1.mc_op2);
      end
      n_checks++;
      if ({bus3.hi_o, bus3.lo_o} !== RST3) begin
         n_fail++;
         $display("FAIL reset_hilo3: got %h_%h expected %h", bus3.hi_o, bus3.lo_o, RST3);
      end
      $display("reset: hilo1=%h_%h hilo3=%h_%h", bus1.hi_o, bus1.lo_o, bus3.hi_o, bus3.lo_o);
   endtask

   // --------------------------------------------------------------------------
   task automatic test_mult();
      req1(3'b000, 32'hFFFFFFFD, 32'd5);
      tick();                                   // E0: accept
      bus1.req_valid = 1'b0;
      n_checks++;
      if ({bus1.busy, bus1.req_ready, bus1.mc_sign_en} !== 3'b101) begin
         n_fail++;
         $display("FAIL mult_wait_status: busy/ready/sign got %b expected 101",
                  {bus1.busy, bus1.req_ready, bus1.mc_sign_en});
      end
      n_checks++;
      if ({bus1.mc_op1, bus1.mc_op2} !== {32'hFFFFFFFD, 32'd5}) begin
         n_fail++;
         $display("FAIL mult_ops: got %h %h expected fffffffd 00000005", bus1.mc_op1, bus1.mc_op2);
      end
      tick();                                   // E1: into WB
      n_checks++;
      if ({bus1.done, bus1.busy, bus1.hi_o, bus1.lo_o} !== {2'b01, 64'h0}) begin
         n_fail++;
         $display("FAIL mult_wb: done/busy=%b%b hilo=%h_%h expected 01 0",
                  bus1.done, bus1.busy, bus1.hi_o, bus1.lo_o);
      end
      tick();                                   // E2: write
      n_checks++;
      if ({bus1.done, bus1.hi_o, bus1.lo_o} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1}) begin
         n_fail++;
         $display("FAIL mult_result: done=%b hilo=%h_%h expected 1 ffffffff_fffffff1",
                  bus1.done, bus1.hi_o, bus1.lo_o);
      end
      $display("MULT -3*5: hi=%h lo=%h done=%b", bus1.hi_o, bus1.lo_o, bus1.done);
      tick();
      n_checks++;
      if (bus1.done !== 1'b0) begin
         n_fail++;
         $display("FAIL mult_done_pulse: done got %b expected 0", bus1.done);
      end
   endtask

   // --------------------------------------------------------------------------
   task automatic test_multu();
      req1(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tick();
      bus1.req_valid = 1'b0;
      n_checks++;
      if (bus1.mc_sign_en !== 1'b0) begin
         n_fail++;
         $display("FAIL multu_sign: got %b expected 0", bus1.mc_sign_en);
      end
      tick(); tick();
      n_checks++;
      if ({bus1.done, bus1.hi_o, bus1.lo_o} !== {1'b1, 32'hFFFFFFFE, 32'h00000001}) begin
         n_fail++;
         $display("FAIL multu_result: done=%b hilo=%h_%h expected 1 fffffffe_00000001",
                  bus1.done, bus1.hi_o, bus1.lo_o);
      end
      $display("MULTU ffffffff^2: hi=%h lo=%h", bus1.hi_o, bus1.lo_o);
      req1(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tick();
      bus1.req_valid = 1'b0;
      tick(); tick();
      n_checks++;
      if ({bus1.done, bus1.hi_o, bus1.lo_o} !== {1'b1, 32'h0, 32'h1}) begin
         n_fail++;
         $display("FAIL mult_m1sq: done=%b hilo=%h_%h expected 1 00000000_00000001",
                  bus1.done, bus1.hi_o, bus1.lo_o);
      end
      $display("MULT -1*-1: hi=%h lo=%h", bus1.hi_o, bus1.lo_o);
      tick();
   endtask

   // --------------------------------------------------------------------------
   task automatic test_madd_msub();
      // MTHI 0, MTLO ffffffff
      bus1.mthi_we = 1'b1; bus1.mt_data = 32'h0;
      tick();
      bus1.mthi_we = 1'b0; bus1.mtlo_we = 1'b1; bus1.mt_data = 32'hFFFFFFFF;
      tick();
      bus1.mtlo_we = 1'b0;
      n_checks++;
      if ({bus1.hi_o, bus1.lo_o} !== 64'h00000000_FFFFFFFF) begin
         n_fail++;
         $display("FAIL mt_moves: hilo=%h_%h expected 00000000_ffffffff", bus1.hi_o, bus1.lo_o);
      end
      req1(3'b011, 32'd1, 32'd1);               // MADDU 1*1
      tick();
      bus1.req_valid = 1'b0;
      tick(); tick();
      n_checks++;
      if ({bus1.done, bus1.hi_o, bus1.lo_o} !== {1'b1, 32'h1, 32'h0}) begin
         n_fail++;
         $display("FAIL maddu_carry: done=%b hilo=%h_%h expected 1 00000001_00000000",
                  bus1.done, bus1.hi_o, bus1.lo_o);
      end
      $display("MADDU 1*1: hi=%h lo=%h", bus1.hi_o, bus1.lo_o);

      // Clear both halves in one move cycle, then MSUB 2*3
      bus1.mthi_we = 1'b1; bus1.mtlo_we = 1'b1; bus1.mt_data = 32'h0;
      tick();
      bus1.mthi_we = 1'b0; bus1.mtlo_we = 1'b0;
      req1(3'b100, 32'd2, 32'd3);
      tick();
      bus1.req_valid = 1'b0;
      n_checks++;
      if (bus1.mc_sign_en !== 1'b1) begin
         n_fail++;
         $display("FAIL msub_sign: got %b expected 1", bus1.mc_sign_en);
      end
      tick(); tick();
      n_checks++;
      if ({bus1.done, bus1.hi_o, bus1.lo_o} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA}) begin
         n_fail++;
         $display("FAIL msub_borrow: done=%b hilo=%h_%h expected 1 ffffffff_fffffffa",
                  bus1.done, bus1.hi_o, bus1.lo_o);
      end
      $display("MSUB 0-2*3: hi=%h lo=%h", bus1.hi_o, bus1.lo_o);

      // Move accepted alongside a MADD, plus an illegal move while busy
      bus1.mthi_we = 1'b1; bus1.mtlo_we = 1'b1; bus1.mt_data = 32'h0;
      tick();
      bus1.mthi_we = 1'b0;
      bus1.mt_data = 32'h10;                    // MTLO 0x10 with the accept
      req1(3'b010, 32'd2, 32'd3);
      tick();
      bus1.req_valid = 1'b0; bus1.mtlo_we = 1'b0;
      n_checks++;
      if ({bus1.hi_o, bus1.lo_o} !== 64'h00000000_00000010) begin
         n_fail++;
         $display("FAIL mt_with_accept: hilo=%h_%h expected 00000000_00000010",
                  bus1.hi_o, bus1.lo_o);
      end
      bus1.mthi_we = 1'b1; bus1.mt_data = 32'hDEAD;   // ignored: busy
      tick();
      bus1.mthi_we = 1'b0;
      tick();
      n_checks++;
      if ({bus1.done, bus1.hi_o, bus1.lo_o} !== {1'b1, 32'h0, 32'h16}) begin
         n_fail++;
         $display("FAIL madd_after_move: done=%b hilo=%h_%h expected 1 00000000_00000016",
                  bus1.done, bus1.hi_o, bus1.lo_o);
      end
      $display("MADD 0x10+2*3 with busy MTHI dropped: hi=%h lo=%h", bus1.hi_o, bus1.lo_o);
      tick();
   endtask

   // --------------------------------------------------------------------------
   task automatic test_flush();
      // Flush in WAIT
      req1(3'b000, 32'd7, 32'd9);
      tick();
      bus1.req_valid = 1'b0;
      bus1.flush = 1'b1;
      tick();
      bus1.flush = 1'b0;
      n_checks++;
      if ({bus1.busy, bus1.req_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL flush_wait_idle: busy/ready got %b expected 01", {bus1.busy, bus1.req_ready});
      end
      tick();
      n_checks++;
      if ({bus1.done, bus1.hi_o, bus1.lo_o} !== {1'b0, 32'h0, 32'h16}) begin
         n_fail++;
         $display("FAIL flush_wait_nowrite: done=%b hilo=%h_%h expected 0 00000000_00000016",
                  bus1.done, bus1.hi_o, bus1.lo_o);
      end
      $display("flush in WAIT: hi=%h lo=%h done=%b", bus1.hi_o, bus1.lo_o, bus1.done);

      // Flush in IDLE blocks the accept
      req1(3'b000, 32'd7, 32'd9);
      bus1.flush = 1'b1;
      tick();
      bus1.req_valid = 1'b0; bus1.flush = 1'b0;
      n_checks++;
      if (bus1.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle_block: busy got %b expected 0", bus1.busy);
      end

      // Flush in WB
      req1(3'b000, 32'd7, 32'd9);
      tick();
      bus1.req_valid = 1'b0;
      tick();
      bus1.flush = 1'b1;
      tick();
      bus1.flush = 1'b0;
      n_checks++;
      if ({bus1.done, bus1.busy, bus1.hi_o, bus1.lo_o} !== {2'b00, 32'h0, 32'h16}) begin
         n_fail++;
         $display("FAIL flush_wb: done/busy=%b%b hilo=%h_%h expected 00 00000000_00000016",
                  bus1.done, bus1.busy, bus1.hi_o, bus1.lo_o);
      end

      // Next request completes normally
      req1(3'b000, 32'd7, 32'd9);
      tick();
      bus1.req_valid = 1'b0;
      tick(); tick();
      n_checks++;
      if ({bus1.done, bus1.hi_o, bus1.lo_o} !== {1'b1, 32'h0, 32'h3F}) begin
         n_fail++;
         $display("FAIL after_flush: done=%b hilo=%h_%h expected 1 00000000_0000003f",
                  bus1.done, bus1.hi_o, bus1.lo_o);
      end
      $display("MULT 7*9 after flushes: hi=%h lo=%h", bus1.hi_o, bus1.lo_o);
      tick();
   endtask

   // --------------------------------------------------------------------------
   task automatic test_reset_mid();
      req1(3'b000, 32'd2, 32'd2);
      tick();
      bus1.req_valid = 1'b0;
      tick();                                   // now in WB
      rstn1 = 1'b0;
      #1;
      n_checks++;
      if ({bus1.busy, bus1.hi_o, bus1.lo_o} !== {1'b0, 64'h0}) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b hilo=%h_%h expected 0 0", bus1.busy, bus1.hi_o, bus1.lo_o);
      end
      tick();
      n_checks++;
      if ({bus1.done, bus1.hi_o, bus1.lo_o} !== 65'h0) begin
         n_fail++;
         $display("FAIL reset_mid_nowrite: done=%b hilo=%h_%h expected 0 0",
                  bus1.done, bus1.hi_o, bus1.lo_o);
      end
      $display("reset in WB: hi=%h lo=%h busy=%b", bus1.hi_o, bus1.lo_o, bus1.busy);
      rstn1 = 1'b1;
      tick();
   endtask

   // --------------------------------------------------------------------------
   task automatic test_back_to_back();
      int n;
      req1(3'b000, 32'd2, 32'd3);
      tick();
      bus1.req_valid = 1'b0;
      tick(); tick();
      n_checks++;
      if ({bus1.done, bus1.lo_o} !== {1'b1, 32'd6}) begin
         n_fail++;
         $display("FAIL b2b_first: done=%b lo=%h expected 1 00000006", bus1.done, bus1.lo_o);
      end
      // Accept in the done cycle itself
      req1(3'b000, 32'd4, 32'd5);
      n = 0;
      do begin
         tick();
         bus1.req_valid = 1'b0;
         n++;
      end while (bus1.done !== 1'b1 && n < 10);
      n_checks++;
      if (n !== 3) begin
         n_fail++;
         $display("FAIL b2b_spacing: done spacing got %0d cycles expected 3", n);
      end
      n_checks++;
      if ({bus1.hi_o, bus1.lo_o} !== 64'd20) begin
         n_fail++;
         $display("FAIL b2b_second: hilo=%h_%h expected 00000000_00000014", bus1.hi_o, bus1.lo_o);
      end
      $display("back-to-back 2*3,4*5: spacing=%0d lo=%h", n, bus1.lo_o);
      tick();
   endtask

   // --------------------------------------------------------------------------
   task automatic test_lat3();
      int n;
      bus3.req_valid = 1'b1; bus3.req_op = 3'b000; bus3.req_a = 32'd6; bus3.req_b = 32'd7;
      tick();                                   // E0
      bus3.req_valid = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
         if (bus3.done !== 1'b1) begin
            n_checks++;
            if ({bus3.hi_o, bus3.lo_o} !== RST3) begin
               n_fail++;
               $display("FAIL lat3_early: edge %0d hilo=%h_%h expected %h", n, bus3.hi_o, bus3.lo_o, RST3);
            end
         end
      end while (bus3.done !== 1'b1 && n < 10);
      n_checks++;
      if (n !== 4) begin
         n_fail++;
         $display("FAIL lat3_latency: done after %0d edges expected 4", n);
      end
      n_checks++;
      if ({bus3.hi_o, bus3.lo_o} !== 64'd42) begin
         n_fail++;
         $display("FAIL lat3_result: hilo=%h_%h expected 00000000_0000002a", bus3.hi_o, bus3.lo_o);
      end
      $display("MC_LAT=3 MULT 6*7: latency=%0d hi=%h lo=%h", n, bus3.hi_o, bus3.lo_o);
      tick();

      // Reserved op: completes, pulses done, no write
      bus3.req_valid = 1'b1; bus3.req_op = 3'b110; bus3.req_a = 32'd3; bus3.req_b = 32'd3;
      tick();
      bus3.req_valid = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus3.done !== 1'b1 && n < 10);
      n_checks++;
      if (n !== 4) begin
         n_fail++;
         $display("FAIL reserved_done: done after %0d edges expected 4", n);
      end
      n_checks++;
      if ({bus3.hi_o, bus3.lo_o} !== 64'd42) begin
         n_fail++;
         $display("FAIL reserved_nowrite: hilo=%h_%h expected 00000000_0000002a", bus3.hi_o, bus3.lo_o);
      end
      $display("MC_LAT=3 reserved op: latency=%0d hi=%h lo=%h", n, bus3.hi_o, bus3.lo_o);
      tick();
   endtask

   // --------------------------------------------------------------------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      rstn1 = 1'b0;
      rstn3 = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rstn1 = 1'b1;
      rstn3 = 1'b1;
      tick();
      test_mult();
      test_multu();
      test_madd_msub();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_lat3();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
